// File: rtl/modbus_bus_arbiter_pkg.sv
// Shared types and constants for the two-requester Modbus register-bus arbiter.
// The optional bus watchdog is enabled with MODBUS_ARB_TIMEOUT_EN.
package modbus_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam int AW_DEF      = 16;
  localparam int DW_DEF      = 16;
  localparam int TIMEOUT_DEF = 255;

  // Exception the endpoint reports when a request ends with err set.
  localparam logic [7:0] EXC_SLAVE_DEVICE_FAILURE = 8'h04;

  function automatic int cnt_width(input int limit);
    return ($clog2(limit + 1) > 8) ? $clog2(limit + 1) : 8;
  endfunction

endpackage

// File: rtl/modbus_bus_arbiter_if.sv
// Requester-side valid/ack interface and downstream register-bus interface.
// master drives the request, slave answers it.
interface modbus_req_if
  import modbus_bus_arbiter_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);
  logic          valid;
  logic [AW-1:0] addr;
  logic          we;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          ack;
  logic          err;

  modport master (output valid, addr, we, wdata, input  rdata, ack, err);
  modport slave  (input  valid, addr, we, wdata, output rdata, ack, err);
endinterface

interface modbus_reg_bus_if
  import modbus_bus_arbiter_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);
  logic          valid;
  logic [AW-1:0] addr;
  logic          we;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          ack;

  modport master (output valid, addr, we, wdata, input  rdata, ack);
  modport slave  (input  valid, addr, we, wdata, output rdata, ack);
endinterface

// File: rtl/modbus_bus_watchdog.sv
// Cycle counter with expiry flag bounding a downstream bus cycle.
// Present only when MODBUS_ARB_TIMEOUT_EN is defined.
`ifdef MODBUS_ARB_TIMEOUT_EN
module modbus_bus_watchdog #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_run,
  input  logic [CW-1:0] i_limit,
  output logic          o_expired
);
  logic [CW-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       r_count <= '0;
    else if (!i_run) r_count <= '0;
    else             r_count <= r_count + 1'b1;
  end

  assign o_expired = i_run && (r_count == i_limit);
endmodule
`endif

// File: rtl/modbus_bus_arbiter.sv
// Round-robin arbiter sharing one holding-register bus between two requesters.
// Define MODBUS_ARB_TIMEOUT_EN to bound each bus cycle and flag expiry via err.
module modbus_bus_arbiter
  import modbus_bus_arbiter_pkg::*;
#(
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  modbus_req_if.slave       r0,
  modbus_req_if.slave       r1,
  modbus_reg_bus_if.master  m
);
  state_t        r_state;
  logic          r_sel;
  logic          r_last_grant;
  logic          r_dropped;
  logic          r_m_valid;
  logic          r_m_we;
  logic [AW-1:0] r_m_addr;
  logic [DW-1:0] r_m_wdata;
  logic [1:0]    r_ack;
  logic [1:0]    r_err;
  logic [DW-1:0] r_rdata [2];

  logic [1:0] w_valid;
  logic       w_grant;
  logic       w_sel_valid;
  logic       w_dropped;
  logic       w_expired;

  assign w_valid     = {r1.valid, r0.valid};
  // Requester 1 wins alone, or on a tie when requester 0 was served last.
  assign w_grant     = w_valid[1] & (~w_valid[0] | ~r_last_grant);
  assign w_sel_valid = w_valid[r_sel];
  assign w_dropped   = r_dropped | ~w_sel_valid;

`ifdef MODBUS_ARB_TIMEOUT_EN
  localparam int CW = cnt_width(TIMEOUT);

  modbus_bus_watchdog #(.CW(CW)) u_watchdog (
    .clk       (clk),
    .reset     (reset),
    .i_run     (r_state == S_BUS),
    .i_limit   (CW'(TIMEOUT)),
    .o_expired (w_expired)
  );
`else
  assign w_expired = 1'b0;
`endif

  // NOTE: all state here is sequential, so every assignment is non-blocking;
  // blocking writes would let later statements see this cycle's new values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_sel        <= 1'b0;
      r_last_grant <= 1'b1;
      r_dropped    <= 1'b0;
      r_m_valid    <= 1'b0;
      r_m_we       <= 1'b0;
      r_m_addr     <= '0;
      r_m_wdata    <= '0;
      r_ack        <= '0;
      r_err        <= '0;
      // NOTE: the read-data holders are ordinary output flops, not a RAM,
      // so they are reset so both requesters see 0 from the first cycle.
      r_rdata[0]   <= '0;
      r_rdata[1]   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|w_valid) begin
            r_sel        <= w_grant;
            r_last_grant <= w_grant;
            r_dropped    <= 1'b0;
            r_m_valid    <= 1'b1;
            r_m_addr     <= w_grant ? r1.addr  : r0.addr;
            r_m_we       <= w_grant ? r1.we    : r0.we;
            r_m_wdata    <= w_grant ? r1.wdata : r0.wdata;
            r_state      <= S_BUS;
          end
        end
        S_BUS: begin
          if (m.ack) begin
            r_m_valid <= 1'b0;
            if (w_dropped) begin
              r_state <= S_IDLE;
            end else begin
              r_ack[r_sel]   <= 1'b1;
              r_err[r_sel]   <= 1'b0;
              r_rdata[r_sel] <= r_m_we ? '0 : m.rdata;
              r_state        <= S_RESP;
            end
          end else if (w_expired) begin
            r_m_valid <= 1'b0;
            if (w_dropped) begin
              r_state <= S_IDLE;
            end else begin
              r_ack[r_sel]   <= 1'b1;
              r_err[r_sel]   <= 1'b1;
              r_rdata[r_sel] <= '0;
              r_state        <= S_RESP;
            end
          end else begin
            r_dropped <= w_dropped;
          end
        end
        S_RESP: begin
          if (!w_sel_valid) begin
            r_ack      <= '0;
            r_err      <= '0;
            r_rdata[0] <= '0;
            r_rdata[1] <= '0;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign m.valid  = r_m_valid;
  assign m.addr   = r_m_addr;
  assign m.we     = r_m_we;
  assign m.wdata  = r_m_wdata;
  assign r0.ack   = r_ack[0];
  assign r0.err   = r_err[0];
  assign r0.rdata = r_rdata[0];
  assign r1.ack   = r_ack[1];
  assign r1.err   = r_err[1];
  assign r1.rdata = r_rdata[1];
endmodule

// File: tb/tb_modbus_bus_arbiter.sv
// Directed bench for modbus_bus_arbiter; timeout cases run when
// MODBUS_ARB_TIMEOUT_EN is defined (bench then uses TIMEOUT=20).
module tb_modbus_bus_arbiter;
  import modbus_bus_arbiter_pkg::*;

  localparam int AW = 16;
  localparam int DW = 16;
`ifdef MODBUS_ARB_TIMEOUT_EN
  localparam int TMO = 20;
`else
  localparam int TMO = TIMEOUT_DEF;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  modbus_req_if     #(.AW(AW), .DW(DW)) r0_if ();
  modbus_req_if     #(.AW(AW), .DW(DW)) r1_if ();
  modbus_reg_bus_if #(.AW(AW), .DW(DW)) m_if  ();

  modbus_bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .r0    (r0_if),
    .r1    (r1_if),
    .m     (m_if)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic req(input int who, input logic v, input logic [15:0] a,
                     input logic we, input logic [15:0] wd);
    if (who == 0) begin
      r0_if.valid = v; r0_if.addr = a; r0_if.we = we; r0_if.wdata = wd;
    end else begin
      r1_if.valid = v; r1_if.addr = a; r1_if.we = we; r1_if.wdata = wd;
    end
  endtask

  function automatic logic ack_of(input int who);
    return (who == 0) ? r0_if.ack : r1_if.ack;
  endfunction

  function automatic logic [15:0] rdata_of(input int who);
    return (who == 0) ? r0_if.rdata : r1_if.rdata;
  endfunction

  task automatic apply_reset();
    reset = 1'b1;
    req(0, 1'b0, 16'h0, 1'b0, 16'h0);
    req(1, 1'b0, 16'h0, 1'b0, 16'h0);
    m_if.ack   = 1'b0;
    m_if.rdata = 16'hdead;
    tick(2);
    reset = 1'b0;
    tick(1);
  endtask

  // Wait (bounded) for a downstream request and check what it carries.
  task automatic wait_grant(input string tag, input logic [15:0] a,
                            input logic we, input logic [15:0] wd);
    for (int i = 0; i < 50 && m_if.valid !== 1'b1; i++) tick();
    check({tag, "_mvalid"}, m_if.valid, 1);
    check({tag, "_maddr"},  m_if.addr,  a);
    check({tag, "_mwe"},    m_if.we,    we);
    if (we) check({tag, "_mwdata"}, m_if.wdata, wd);
  endtask

  // m_ack is sampled at the delay-th rising edge after the current negedge.
  task automatic pulse_ack(input int delay, input logic [15:0] data);
    if (delay > 1) tick(delay - 1);
    m_if.ack   = 1'b1;
    m_if.rdata = data;
    tick();
    m_if.ack   = 1'b0;
    m_if.rdata = 16'hdead;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "bench time limit");
  end

  int          who;
  logic [15:0] a;

  initial begin
    apply_reset();
    check("rst_state",  dut.r_state, S_IDLE);
    check("rst_mvalid", m_if.valid,  0);
    check("rst_r0ack",  r0_if.ack,   0);
    check("rst_r1ack",  r1_if.ack,   0);

    // Single read from requester 0, bus answers 0xabcd after 3 cycles.
    req(0, 1'b1, 16'h0000, 1'b0, 16'h0);
    tick();
    check("rd_latency", m_if.valid, 1);
    wait_grant("rd", 16'h0000, 1'b0, 16'h0);
    pulse_ack(3, 16'habcd);
    check("rd_r0ack",   r0_if.ack,   1);
    check("rd_r0rdata", r0_if.rdata, 16'habcd);
    check("rd_r0err",   r0_if.err,   0);
    check("rd_r1ack",   r1_if.ack,   0);
    check("rd_mvalid",  m_if.valid,  0);
    tick(2);
    check("rd_hold_ack",   r0_if.ack,   1);
    check("rd_hold_rdata", r0_if.rdata, 16'habcd);
    req(0, 1'b0, 16'h0000, 1'b0, 16'h0);
    tick();
    check("rd_rel_ack",   r0_if.ack,   0);
    check("rd_rel_rdata", r0_if.rdata, 0);
    check("rd_rel_state", dut.r_state, S_IDLE);

    // Both requesters held: order must be 0,1,0,1 starting from reset.
    apply_reset();
    req(0, 1'b1, 16'h1234, 1'b0, 16'h0);
    req(1, 1'b1, 16'h1235, 1'b0, 16'h0);
    for (int i = 0; i < 4; i++) begin
      who = i % 2;
      a   = (who == 0) ? 16'h1234 : 16'h1235;
      wait_grant($sformatf("rr%0d", i), a, 1'b0, 16'h0);
      pulse_ack(2, 16'habcd ^ a);
      check($sformatf("rr%0d_ack", i),   ack_of(who),     1);
      check($sformatf("rr%0d_rdata", i), rdata_of(who),   16'habcd ^ a);
      check($sformatf("rr%0d_other", i), ack_of(1 - who), 0);
      req(who, 1'b0, a, 1'b0, 16'h0);
      tick();
      check($sformatf("rr%0d_rel", i), ack_of(who), 0);
      if (i < 2) req(who, 1'b1, a, 1'b0, 16'h0);
    end

    // Write from requester 1: rdata returned to the requester must be 0.
    req(1, 1'b1, 16'h0010, 1'b1, 16'h5a5a);
    wait_grant("wr", 16'h0010, 1'b1, 16'h5a5a);
    pulse_ack(2, 16'hffff);
    check("wr_r1ack",   r1_if.ack,   1);
    check("wr_r1rdata", r1_if.rdata, 0);
    check("wr_r0ack",   r0_if.ack,   0);
    req(1, 1'b0, 16'h0010, 1'b0, 16'h0);
    tick();
    check("wr_rel", r1_if.ack, 0);

    // Requester 0 aborts mid-cycle: bus cycle completes, no ack returned.
    req(0, 1'b1, 16'h0020, 1'b0, 16'h0);
    wait_grant("ab", 16'h0020, 1'b0, 16'h0);
    req(0, 1'b0, 16'h0020, 1'b0, 16'h0);
    tick(2);
    check("ab_mvalid_held", m_if.valid, 1);
    pulse_ack(1, 16'h1111);
    check("ab_r0ack",  r0_if.ack,   0);
    check("ab_mvalid", m_if.valid,  0);
    check("ab_state",  dut.r_state, S_IDLE);
    req(1, 1'b1, 16'h0030, 1'b0, 16'h0);
    wait_grant("ab_next", 16'h0030, 1'b0, 16'h0);
    pulse_ack(1, 16'h7777);
    check("ab_next_ack",   r1_if.ack,   1);
    check("ab_next_rdata", r1_if.rdata, 16'h7777);
    req(1, 1'b0, 16'h0030, 1'b0, 16'h0);
    tick();

`ifdef MODBUS_ARB_TIMEOUT_EN
    // No m_ack: expiry after the 21st edge in S_BUS (count reaches 20).
    req(0, 1'b1, 16'h0040, 1'b0, 16'h0);
    wait_grant("to", 16'h0040, 1'b0, 16'h0);
    tick(20);
    check("to_pre_mvalid", m_if.valid, 1);
    check("to_pre_ack",    r0_if.ack,  0);
    tick();
    check("to_mvalid", m_if.valid,  0);
    check("to_ack",    r0_if.ack,   1);
    check("to_err",    r0_if.err,   1);
    check("to_rdata",  r0_if.rdata, 0);
    req(0, 1'b0, 16'h0040, 1'b0, 16'h0);
    tick();
    check("to_rel_err", r0_if.err, 0);

    // m_ack on the expiry edge wins: normal completion.
    req(1, 1'b1, 16'h0050, 1'b0, 16'h0);
    wait_grant("tw", 16'h0050, 1'b0, 16'h0);
    pulse_ack(21, 16'h4242);
    check("tw_ack",   r1_if.ack,   1);
    check("tw_err",   r1_if.err,   0);
    check("tw_rdata", r1_if.rdata, 16'h4242);
    req(1, 1'b0, 16'h0050, 1'b0, 16'h0);
    tick();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
